// File: rtl/vector_line_feeder.sv
// vector_line_feeder: walks a display list in vector RAM and feeds one line at a time to the rasterizer.
// Optional macro VECTOR_FEEDER_SKIP_BLANK_EN: color-0 entries are consumed without being issued.
`default_nettype none

module vector_line_feeder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_LINES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [63:0]       mem_data,
  output logic [12:0]       startX,
  output logic [12:0]       startY,
  output logic [12:0]       endX,
  output logic [12:0]       endY,
  output logic [3:0]        lineColor,
  output logic              readyIn,
  input  logic              rastReady,
  input  logic              rastDone,
  output logic              busy,
  output logic              list_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] line_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_LINES);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              abort_seen_q, abort_seen_d;
  logic              last_q, last_d;
  logic [12:0]       sx_q, sx_d, sy_q, sy_d, ex_q, ex_d, ey_q, ey_d;
  logic [3:0]        color_q, color_d;

  logic w_abort_any;
  logic w_last_src;
  logic w_at_max;
  logic w_end;
  logic w_unused_rsvd;

  assign w_unused_rsvd = ^mem_data[62:56];
  assign w_abort_any   = abort | abort_seen_q;
  assign w_at_max      = (cnt_q == MAX_CNT);
  // The exit decision is taken in DRAIN from the latched flag, or in WAIT straight off the RAM for skipped entries.
  assign w_last_src    = (state_q == S_WAIT) ? mem_data[63] : last_q;
  assign w_end         = w_last_src | w_abort_any | w_at_max;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    abort_seen_d = abort_seen_q;
    last_d       = last_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    ex_d         = ex_q;
    ey_d         = ey_q;
    color_d      = color_q;

    if (state_q != S_IDLE && abort) begin
      abort_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FETCH;
          ptr_d        = base_addr;
          cnt_d        = '0;
          ovf_d        = 1'b0;
          abort_seen_d = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = w_abort_any ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        sx_d    = mem_data[12:0];
        sy_d    = mem_data[25:13];
        ex_d    = mem_data[38:26];
        ey_d    = mem_data[51:39];
        color_d = mem_data[55:52];
        last_d  = mem_data[63];
        if (w_abort_any) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_ISSUE;
`ifdef VECTOR_FEEDER_SKIP_BLANK_EN
          if (mem_data[55:52] == 4'd0) begin
            if (w_end) begin
              state_d = S_FINISH;
              if (w_at_max && !w_last_src) ovf_d = 1'b1;
            end else begin
              state_d = S_FETCH;
              ptr_d   = ptr_q + 1'b1;
            end
          end
`endif
        end
      end
      S_ISSUE: begin
        // Abort wins over a coincident rastReady so a dropped line is never counted.
        if (w_abort_any) begin
          state_d = S_FINISH;
        end else if (rastReady) begin
          state_d = S_DRAIN;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (rastDone) begin
          if (w_end) begin
            state_d = S_FINISH;
            if (w_at_max && !w_last_src) ovf_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      abort_seen_q <= 1'b0;
      last_q       <= 1'b0;
      sx_q         <= '0;
      sy_q         <= '0;
      ex_q         <= '0;
      ey_q         <= '0;
      color_q      <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      abort_seen_q <= abort_seen_d;
      last_q       <= last_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      ex_q         <= ex_d;
      ey_q         <= ey_d;
      color_q      <= color_d;
    end
  end

  assign mem_addr   = ptr_q;
  assign mem_rd     = (state_q == S_FETCH);
  assign readyIn    = (state_q == S_ISSUE) & ~abort & ~rst;
  assign busy       = (state_q != S_IDLE);
  assign list_done  = (state_q == S_FINISH);
  assign overflow   = ovf_q;
  assign line_count = cnt_q;
  assign startX     = sx_q;
  assign startY     = sy_q;
  assign endX       = ex_q;
  assign endY       = ey_q;
  assign lineColor  = color_q;

endmodule

`default_nettype wire
